// File: rtl/intersection_scheduler_if.sv
// Signal bundle between sensor/timebase logic (master) and the scheduler (slave).
interface intersection_scheduler_if;
  logic       tick;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       preempt;
  logic       preempt_dir;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output tick, ns_req, ew_req, ped_req, preempt, preempt_dir,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  tick, ns_req, ew_req, ped_req, preempt, preempt_dir,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach intersection sequencer: timed phases, demand-driven green rest,
// latched pedestrian walk and emergency preemption. Outputs are registered
// and decoded from the state being entered, so they always match the state.
module intersection_scheduler #(
  parameter int TW           = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int FLASH_TICKS  = 4,
  parameter int YELLOW_TICKS = 6,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input logic                      clk,
  input logic                      rstb,
  intersection_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    ALLRED = 3'd0, NS_G = 3'd1, NS_F = 3'd2, NS_Y = 3'd3,
    EW_G   = 3'd4, EW_F = 3'd5, EW_Y = 3'd6, WALK = 3'd7
  } state_t;

  localparam logic [1:0] LG = 2'b00, LF = 2'b01, LY = 2'b11, LR = 2'b10;

  state_t        state, nxt;
  logic [TW-1:0] timer, nxt_timer;
  logic          next_dir, nxt_dir;   // 0 = NS, 1 = EW
  logic          ped_pending;
  logic          cur_dir, gf, opp_req, enter_walk;

  function automatic logic [TW-1:0] dur(input state_t s);
    case (s)
      NS_G, EW_G: dur = TW'(GREEN_TICKS - 1);
      NS_F, EW_F: dur = TW'(FLASH_TICKS - 1);
      NS_Y, EW_Y: dur = TW'(YELLOW_TICKS - 1);
      WALK:       dur = TW'(WALK_TICKS - 1);
      default:    dur = TW'(ALLRED_TICKS - 1);
    endcase
  endfunction

  function automatic state_t green_of(input logic d);
    if (d) green_of = EW_G; else green_of = NS_G;
  endfunction

  function automatic state_t flash_of(input logic d);
    if (d) flash_of = EW_F; else flash_of = NS_F;
  endfunction

  function automatic state_t yellow_of(input logic d);
    if (d) yellow_of = EW_Y; else yellow_of = NS_Y;
  endfunction

  function automatic logic [1:0] ns_code(input state_t s);
    case (s)
      NS_G:    ns_code = LG;
      NS_F:    ns_code = LF;
      NS_Y:    ns_code = LY;
      default: ns_code = LR;
    endcase
  endfunction

  function automatic logic [1:0] ew_code(input state_t s);
    case (s)
      EW_G:    ew_code = LG;
      EW_F:    ew_code = LF;
      EW_Y:    ew_code = LY;
      default: ew_code = LR;
    endcase
  endfunction

  // Next-state / timer / direction: preemption acts every cycle, timed exits only on tick.
  always_comb begin
    nxt       = state;
    nxt_timer = timer;
    nxt_dir   = next_dir;
    cur_dir   = (state inside {EW_G, EW_F, EW_Y});
    gf        = (state inside {NS_G, NS_F, EW_G, EW_F});
    opp_req   = cur_dir ? bus.ns_req : bus.ew_req;

    if (bus.preempt && gf && (cur_dir == bus.preempt_dir)) begin
      // Preempting approach keeps (or regains) green, parked at timer 0.
      nxt       = green_of(cur_dir);
      nxt_timer = '0;
    end else if (bus.preempt && gf) begin
      nxt       = yellow_of(cur_dir);
      nxt_timer = dur(yellow_of(cur_dir));
    end else if (bus.preempt && state == WALK) begin
      nxt       = ALLRED;
      nxt_timer = dur(ALLRED);
    end else if (bus.tick) begin
      if (timer != '0) begin
        nxt_timer = timer - TW'(1);
      end else begin
        case (state)
          NS_G, EW_G: if (opp_req || ped_pending) nxt = flash_of(cur_dir);
          NS_F, EW_F: nxt = yellow_of(cur_dir);
          NS_Y, EW_Y: begin
            nxt     = ALLRED;
            nxt_dir = ~cur_dir;
          end
          ALLRED: begin
            if (bus.preempt) begin
              nxt     = green_of(bus.preempt_dir);
              nxt_dir = ~bus.preempt_dir;
            end else if (ped_pending) begin
              nxt = WALK;
            end else begin
              nxt = green_of(next_dir);
            end
          end
          default: nxt = green_of(next_dir);  // WALK
        endcase
        // Green rest keeps state with timer at 0; any real move reloads.
        if (nxt != state) nxt_timer = dur(nxt);
      end
    end

    enter_walk = (nxt == WALK) && (state != WALK);
  end

  // State, pedestrian latch and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= ALLRED;
      timer        <= TW'(ALLRED_TICKS - 1);
      next_dir     <= 1'b0;
      ped_pending  <= 1'b0;
      bus.ns_light <= LR;
      bus.ew_light <= LR;
      bus.walk     <= 1'b0;
      bus.ped_ack  <= 1'b0;
      bus.phase    <= 3'd0;
    end else begin
      state        <= nxt;
      timer        <= nxt_timer;
      next_dir     <= nxt_dir;
      // A new press on the serving cycle wins over the clear.
      ped_pending  <= bus.ped_req | (ped_pending & ~enter_walk);
      bus.ns_light <= ns_code(nxt);
      bus.ew_light <= ew_code(nxt);
      bus.walk     <= (nxt == WALK);
      bus.ped_ack  <= enter_walk;
      bus.phase    <= nxt;
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with short phase durations.
module tb_intersection_scheduler;
  logic clk  = 1'b0;
  logic rstb = 1'b1;
  int   tests = 0;
  int   fails = 0;

  intersection_scheduler_if bus();

  intersection_scheduler #(
    .TW(8), .GREEN_TICKS(4), .FLASH_TICKS(2), .YELLOW_TICKS(3),
    .ALLRED_TICKS(1), .WALK_TICKS(5)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ns_of(input int p);
    case (p)
      1:       ns_of = 2'b00;
      2:       ns_of = 2'b01;
      3:       ns_of = 2'b11;
      default: ns_of = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] ew_of(input int p);
    case (p)
      4:       ew_of = 2'b00;
      5:       ew_of = 2'b01;
      6:       ew_of = 2'b11;
      default: ew_of = 2'b10;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_st(input string tag, input int p, input logic ack);
    chk({tag, " phase"},    8'(bus.phase),    8'(p));
    chk({tag, " ns_light"}, 8'(bus.ns_light), 8'(ns_of(p)));
    chk({tag, " ew_light"}, 8'(bus.ew_light), 8'(ew_of(p)));
    chk({tag, " walk"},     8'(bus.walk),     8'(p == 7));
    chk({tag, " ped_ack"},  8'(bus.ped_ack),  8'(ack));
  endtask

  task automatic run_seq(input string tag, input int seq[$], input int ack_at);
    foreach (seq[i]) begin
      cyc();
      expect_st($sformatf("%s[%0d]", tag, i), seq[i], i == ack_at);
    end
  endtask

  task automatic do_reset(input string tag);
    rstb = 1'b0;
    bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
    bus.preempt = 0; bus.preempt_dir = 0;
    cyc();
    expect_st({tag, ".rst"}, 0, 1'b0);
    rstb = 1'b1;
    expect_st({tag, ".c0"}, 0, 1'b0);
  endtask

  // Both approaches must never show non-red together.
  always @(negedge clk) begin
    if (rstb === 1'b1)
      chk("safety", {7'd0, (bus.ns_light != 2'b10) && (bus.ew_light != 2'b10)}, 8'd0);
  end

  initial begin
    int q[$];
    bus.tick = 1; bus.ns_req = 0; bus.ew_req = 0; bus.ped_req = 0;
    bus.preempt = 0; bus.preempt_dir = 0;
    #3 rstb = 1'b0;

    // No demand: one ALLRED cycle then NS green rests.
    do_reset("t1");
    q = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_seq("t1", q, -1);

    // EW demand: full NS cycle to EW green, which then rests.
    do_reset("t2");
    bus.ew_req = 1;
    q = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 0, 4, 4, 4};
    run_seq("t2", q, -1);

    // Pedestrian press during NS green -> WALK after clearance, then EW.
    do_reset("t3");
    cyc(); expect_st("t3.g0", 1, 1'b0);
    bus.ped_req = 1;
    cyc(); expect_st("t3.g1", 1, 1'b0);
    bus.ped_req = 0;
    q = '{1, 1, 2, 2, 3, 3, 3, 0, 7, 7, 7, 7, 7, 4, 4, 4};
    run_seq("t3", q, 8);

    // Preempt toward EW in NS green cycle 2; release on first EW green cycle.
    do_reset("t4");
    cyc(); expect_st("t4.g0", 1, 1'b0);
    cyc(); expect_st("t4.g1", 1, 1'b0);
    bus.preempt = 1; bus.preempt_dir = 1;
    q = '{3, 3, 3, 0, 4};
    run_seq("t4a", q, -1);
    bus.preempt = 0; bus.ns_req = 1;
    q = '{4, 4, 4, 5, 5, 6, 6, 6, 0, 1};
    run_seq("t4b", q, -1);

    // Preempt toward NS while in NS green parks the timer at 0; release exits at once.
    bus.preempt = 1; bus.preempt_dir = 0; bus.ew_req = 1;
    q = '{1, 1, 1, 1, 1, 1};
    run_seq("t5a", q, -1);
    bus.preempt = 0;
    q = '{2, 2, 3, 3, 3, 0, 4};
    run_seq("t5b", q, -1);

    // Preempt during WALK aborts through ALLRED; pending is not re-armed.
    do_reset("t6");
    bus.ped_req = 1;
    cyc(); expect_st("t6.g0", 1, 1'b0);
    bus.ped_req = 0;
    q = '{1, 1, 1, 2, 2, 3, 3, 3, 0, 7};
    run_seq("t6a", q, 9);
    bus.preempt = 1; bus.preempt_dir = 0;
    q = '{0, 1, 1};
    run_seq("t6b", q, -1);
    bus.preempt = 0;
    q = '{1, 1, 1, 1};
    run_seq("t6c", q, -1);

    // Asynchronous reset mid-yellow takes effect without a clock edge.
    do_reset("t7");
    bus.ew_req = 1;
    q = '{1, 1, 1, 1, 2, 2, 3};
    run_seq("t7", q, -1);
    #2 rstb = 1'b0;
    #1 expect_st("t7.async", 0, 1'b0);
    cyc(); expect_st("t7.hold", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
